// File: rtl/r_moore_pkg.sv
// r_moore_pkg: shared constants, state-width helper and legacy "101" state names
package r_moore_pkg;
  localparam int DEF_LEN = 3;
  localparam logic [DEF_LEN-1:0] DEF_PATTERN = 3'b101;
  typedef enum logic [1:0] {S0, S1, S2, S3} legacy_state_t;
  function automatic int state_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/r_moore_match.sv
// r_moore_match: longest suffix of the history that is a prefix of the pattern
module r_moore_match
  import r_moore_pkg::*;
#(
  parameter int PATTERN_LEN = DEF_LEN,
  localparam int SW = state_w(PATTERN_LEN)
) (
  input  logic [PATTERN_LEN-1:0] h_i,
  input  logic [SW-1:0]          hcnt_i,
  input  logic [PATTERN_LEN-1:0] pat_i,
  output logic [SW-1:0]          len_o
);
  always_comb begin
    len_o = '0;
    for (int j = 1; j <= PATTERN_LEN; j++)
      if (SW'(j) <= hcnt_i &&
          ((h_i ^ (pat_i >> (PATTERN_LEN - j))) & ({PATTERN_LEN{1'b1}} >> (PATTERN_LEN - j))) == '0)
        len_o = SW'(j);
  end
endmodule

// File: rtl/r_moore_seq.sv
// r_moore_seq: parametrised Moore sequence detector with loadable pattern and overlap select
// Define R_MOORE_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module r_moore_seq
  import r_moore_pkg::*;
#(
  parameter int PATTERN_LEN = DEF_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN = PATTERN_LEN'(DEF_PATTERN),
  parameter int CNT_W = 8,
  localparam int SW = state_w(PATTERN_LEN)
) (
  input  logic                   clk,
  input  logic                   r,
  input  logic                   en,
  input  logic                   X,
  input  logic                   ovl,
  input  logic                   load,
  input  logic [PATTERN_LEN-1:0] pat_in,
  output logic                   Y,
  output logic [SW-1:0]          ac_state,
  output logic [CNT_W-1:0]       match_cnt
);
  logic [PATTERN_LEN-1:0] hist_q, hist_d, pat_q;
  logic [SW-1:0] hcnt_q, hcnt_d, ac_q, ac_d;
  logic [PATTERN_LEN:0] sh;
  logic clr, y_q;
  // a completed match in non-overlap mode restarts from an empty history
  always_comb begin
    clr = !ovl && ac_q == SW'(PATTERN_LEN);
    sh = {clr ? '0 : hist_q, X};
    hist_d = sh[PATTERN_LEN-1:0];
    hcnt_d = clr ? SW'(1) : (hcnt_q == SW'(PATTERN_LEN) ? hcnt_q : hcnt_q + 1'b1);
  end
  r_moore_match #(.PATTERN_LEN(PATTERN_LEN)) u_match (
    .h_i(hist_d), .hcnt_i(hcnt_d), .pat_i(pat_q), .len_o(ac_d)
  );
  always_ff @(posedge clk) begin
    if (!r) begin
      hist_q <= '0;
      hcnt_q <= '0;
      ac_q   <= '0;
      pat_q  <= PATTERN;
      y_q    <= 1'b0;
    end else if (load) begin
      pat_q  <= pat_in;
      hist_q <= '0;
      hcnt_q <= '0;
      ac_q   <= '0;
      y_q    <= 1'b0;
    end else if (en) begin
      hist_q <= hist_d;
      hcnt_q <= hcnt_d;
      ac_q   <= ac_d;
      y_q    <= ac_d == SW'(PATTERN_LEN);
    end
  end
  assign Y = y_q;
  assign ac_state = ac_q;
`ifdef R_MOORE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!r) cnt_q <= '0;
    else if (!load && en && ac_d == SW'(PATTERN_LEN) && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif
endmodule
